egg_hatch_ctrl: RTL
===================

# egg_hatch_ctrl

Incubation controller for the egg-hatching demo. Sits directly upstream of the dot-matrix display stage: it runs the hatch state machine, keeps the incubator temperature, advances the growth stage `num` (0..11) once per completed stage period at in-range temperature, and drives the display's `st` enable and `temp` warning inputs. Runs on the 1 kHz system clock.

## Interface
- `CLK_HZ`, 1000: clk cycles per second tick
- `STAGE_SEC`, 3: in-range seconds per growth stage
- `MAX_STAGE`, 11: final stage value (hatched)
- `DEAD_SEC`, 5: consecutive out-of-range seconds that kill the egg
- `T_INIT`, 37: temperature after reset (°C)
- `T_LOW`, 36 / `T_HIGH`, 39: inclusive good range
- `T_MIN`, 20 / `T_MAX`, 50: clamp limits
- `DRIFT_SEC`, 4: drift period (see Configuration)
- `clk  in  1  system clock, 1 kHz`
- `rst  in  1  reset, asynchronous, active-high`
- `start  in  1  one-cycle debounced pulse: begin / acknowledge`
- `heat  in  1  one-cycle pulse: temperature +1`
- `cool  in  1  one-cycle pulse: temperature −1`
- `num  out  4  growth stage to display`
- `st  out  1  display enable`
- `temp  out  1  1 = temperature out of range or egg dead (warning colour)`
- `temp_c  out  7  current temperature, unsigned °C`
- `hatched  out  1  high in HATCHED`
- `dead  out  1  high in DEAD`

## Operation
- States: IDLE, RUN, HATCHED, DEAD. Reset → IDLE.
- IDLE: num=0, st=0. `start` → RUN; prescaler, stage-second and bad-second counters cleared on entry.
- RUN: st=1. Prescaler counts 0..CLK_HZ−1; `tick` is the cycle at count CLK_HZ−1.
  - Tick with T_LOW ≤ temp_c ≤ T_HIGH: bad_sec←0; stage_sec+1; when stage_sec reaches STAGE_SEC, stage_sec←0 and num+1. num reaching MAX_STAGE → HATCHED in the same update.
  - Tick out of range: stage_sec holds; bad_sec+1; reaching DEAD_SEC → DEAD.
  - `start` in RUN ignored.
- HATCHED: num=MAX_STAGE, st=1, hatched=1. `start` → IDLE.
- DEAD: num held at value when killed, st=1, dead=1, temp=1. `start` → IDLE.
- Temperature: `heat` +1, `cool` −1, accepted in every state; saturate at T_MAX/T_MIN; heat and cool in same cycle → no change.
- temp = dead | (temp_c < T_LOW) | (temp_c > T_HIGH), combinational from registered state.
- Counter widths sized by $clog2 of their limits; no wrap past limits.

## Timing
- Reset values: num=0, st=0, temp=0, temp_c=T_INIT, hatched=0, dead=0; all counters 0.
- All outputs registered except `temp` (decode of registered values); state change visible the cycle after the causing edge.
- `start` → st=1 one cycle later; first tick exactly CLK_HZ cycles after the `start` cycle.
- Stage n reached STAGE_SEC×n good ticks after start; pauses extend this exactly by the bad ticks.
- Button pulse on a tick cycle: the tick evaluates pre-update temp_c; new temp_c applies from the next tick.
- rst mid-RUN: immediate return to IDLE values regardless of clk.

## Configuration
- `HATCH_DRIFT_EN` defined: in RUN, every DRIFT_SEC-th tick (counted from RUN entry) temp_c decrements by 1, saturating at T_MIN; coinciding with `heat` → net 0, with `cool` → −2 (clamped). Drift counter cleared on entering RUN.
- Not defined: temp_c changes only via heat/cool; drift logic absent.

## Test plan
Sim parameters CLK_HZ=4, STAGE_SEC=2, DEAD_SEC=3, MAX_STAGE=11, drift off unless stated.
- Reset then `start` → st=1 next cycle; num=1 after 8 cycles, num=11, hatched=1 after 88 cycles; further ticks leave num=11.
- RUN at num=3, two `cool` pulses (37→35) → temp=1 immediately; num frozen; after 3 ticks dead=1, num=3; `start` → IDLE, num=0, st=0.
- Out of range for 2 ticks, `heat` back to 36, then out again → bad_sec restarts; no DEAD until 3 consecutive bad ticks.
- 14 `heat` pulses from 37 → temp_c=50 and stays; 31 `cool` pulses → temp_c=20; heat+cool same cycle → unchanged.
- rst asserted between clk edges in RUN at num=5 → num=0, st=0, temp_c=37 without a clock edge.
- `HATCH_DRIFT_EN`, DRIFT_SEC=4: `start`, no buttons → temp_c=36 after 4th tick, 35 after 8th, temp=1 from then; dead=1 after 3rd bad tick (tick 11).

Source files
------------

// File: rtl/egg_hatch_ctrl.sv
// ----------------------------------------------------------------------------
// egg_hatch_ctrl
//
// Incubation controller for the egg-hatching demo. Runs the hatch state
// machine (IDLE / RUN / HATCHED / DEAD), keeps the incubator temperature,
// advances the growth stage once per completed stage period spent at an
// in-range temperature, and drives the dot-matrix display's enable and
// warning inputs.
//
// Optional feature: define HATCH_DRIFT_EN to make the incubator lose one
// degree every DRIFT_SEC-th second tick while running. Without it the
// temperature only moves on heat/cool pulses and no drift logic exists.
//
// Ports
//   clk      in   system clock (1 kHz)
//   rst      in   asynchronous, active-high reset
//   start    in   one-cycle pulse: begin a run / acknowledge end of a run
//   heat     in   one-cycle pulse: temperature +1
//   cool     in   one-cycle pulse: temperature -1
//   num      out  growth stage 0..MAX_STAGE for the display
//   st       out  display enable (high outside IDLE)
//   temp     out  warning: temperature out of range or egg dead
//   temp_c   out  current temperature, unsigned degrees C
//   hatched  out  high in HATCHED
//   dead     out  high in DEAD
// ----------------------------------------------------------------------------
module egg_hatch_ctrl #(
    parameter int CLK_HZ    = 1000,
    parameter int STAGE_SEC = 3,
    parameter int MAX_STAGE = 11,
    parameter int DEAD_SEC  = 5,
    parameter int T_INIT    = 37,
    parameter int T_LOW     = 36,
    parameter int T_HIGH    = 39,
    parameter int T_MIN     = 20,
    parameter int T_MAX     = 50
`ifdef HATCH_DRIFT_EN
    ,
    parameter int DRIFT_SEC = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       heat,
    input  logic       cool,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic [6:0] temp_c,
    output logic       hatched,
    output logic       dead
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int STG_W = $clog2(STAGE_SEC + 1);
    localparam int BAD_W = $clog2(DEAD_SEC + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_SEC - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(DEAD_SEC - 1);
    localparam logic [3:0]       NUM_LAST = 4'(MAX_STAGE - 1);
    localparam logic [3:0]       NUM_MAX  = 4'(MAX_STAGE);

    localparam logic [6:0] TC_INIT = 7'(T_INIT);
    localparam logic [6:0] TC_LOW  = 7'(T_LOW);
    localparam logic [6:0] TC_HIGH = 7'(T_HIGH);

    localparam logic signed [8:0] TS_MIN = 9'(T_MIN);
    localparam logic signed [8:0] TS_MAX = 9'(T_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HATCHED = 2'd2,
        S_DEAD    = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [PRE_W-1:0] presc_q,     presc_d;
    logic [STG_W-1:0] stage_sec_q, stage_sec_d;
    logic [BAD_W-1:0] bad_sec_q,   bad_sec_d;
    logic [3:0]       num_q,       num_d;
    logic [6:0]       temp_c_q,    temp_c_d;
    logic             st_q, hatched_q, dead_q;

    logic             tick;
    logic             in_range;
    logic             drift_pulse;
    logic signed [8:0] temp_step;
    logic signed [8:0] temp_sum;

    // Clamp a widened signed temperature back into T_MIN..T_MAX.
    function automatic logic [6:0] sat_temp(input logic signed [8:0] v);
        logic [6:0] r;
        if (v > TS_MAX) begin
            r = TS_MAX[6:0];
        end else if (v < TS_MIN) begin
            r = TS_MIN[6:0];
        end else begin
            r = v[6:0];
        end
        return r;
    endfunction

    assign tick     = (state_q == S_RUN) && (presc_q == PRE_LAST);
    assign in_range = (temp_c_q >= TC_LOW) && (temp_c_q <= TC_HIGH);

`ifdef HATCH_DRIFT_EN
    localparam int DRF_W = $clog2(DRIFT_SEC + 1);
    localparam logic [DRF_W-1:0] DRF_LAST = DRF_W'(DRIFT_SEC - 1);

    logic [DRF_W-1:0] drift_q, drift_d;

    // Drift count restarts on every RUN entry, so it is held at zero
    // whenever the controller is not running.
    always_comb begin
        drift_d     = drift_q;
        drift_pulse = 1'b0;
        if (state_q != S_RUN) begin
            drift_d = '0;
        end else if (tick) begin
            if (drift_q == DRF_LAST) begin
                drift_d     = '0;
                drift_pulse = 1'b1;
            end else begin
                drift_d = drift_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drift_q <= '0;
        end else begin
            drift_q <= drift_d;
        end
    end
`else
    assign drift_pulse = 1'b0;
`endif

    // Temperature: heat and cool cancel; drift adds a further -1.
    // A press on a tick cycle only affects the next tick because the
    // tick above evaluates temp_c_q, the pre-update value.
    always_comb begin
        temp_step = '0;
        if (heat && !cool) begin
            temp_step = 9'sd1;
        end else if (cool && !heat) begin
            temp_step = -9'sd1;
        end
        if (drift_pulse) begin
            temp_step = temp_step - 9'sd1;
        end
        temp_sum = $signed({2'b00, temp_c_q}) + temp_step;
        temp_c_d = sat_temp(temp_sum);
    end

    // Hatch state machine and second counters
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        stage_sec_d = stage_sec_q;
        bad_sec_d   = bad_sec_q;
        num_d       = num_q;

        case (state_q)
            S_IDLE: begin
                presc_d     = '0;
                stage_sec_d = '0;
                bad_sec_d   = '0;
                num_d       = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (in_range) begin
                        bad_sec_d = '0;
                        if (stage_sec_q == STG_LAST) begin
                            stage_sec_d = '0;
                            num_d       = num_q + 1'b1;
                            if (num_q == NUM_LAST) begin
                                state_d = S_HATCHED;
                            end
                        end else begin
                            stage_sec_d = stage_sec_q + 1'b1;
                        end
                    end else begin
                        bad_sec_d = bad_sec_q + 1'b1;
                        if (bad_sec_q == BAD_LAST) begin
                            state_d = S_DEAD;
                        end
                    end
                end
            end

            S_HATCHED: begin
                num_d = NUM_MAX;
                if (start) begin
                    state_d = S_IDLE;
                end
            end

            S_DEAD: begin
                if (start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving a finished run clears the displayed stage in the same
        // cycle the display is switched off.
        if (state_d == S_IDLE) begin
            num_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            stage_sec_q <= '0;
            bad_sec_q   <= '0;
            num_q       <= '0;
            temp_c_q    <= TC_INIT;
            st_q        <= 1'b0;
            hatched_q   <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            stage_sec_q <= stage_sec_d;
            bad_sec_q   <= bad_sec_d;
            num_q       <= num_d;
            temp_c_q    <= temp_c_d;
            st_q        <= (state_d != S_IDLE);
            hatched_q   <= (state_d == S_HATCHED);
            dead_q      <= (state_d == S_DEAD);
        end
    end

    assign num     = num_q;
    assign st      = st_q;
    assign temp_c  = temp_c_q;
    assign hatched = hatched_q;
    assign dead    = dead_q;
    assign temp    = dead_q || (temp_c_q < TC_LOW) || (temp_c_q > TC_HIGH);

endmodule
